// File: rtl/keypad_scanner.sv
// keypad_scanner: scan-multiplexed 4x4 hex keypad reader with debounce.
// Drives one column low per dwell, samples the synchronized rows at the end of
// each dwell, debounces a single pressed key and shifts its hex code into a
// 32-bit entry register (newest digit in [3:0]).
// Optional feature macro: KEYPAD_SCANNER_CLEAR_EN -- key C clears the entry
// register instead of being shifted in.
// Ports:
//   keypad_scanner_clk         system clock
//   keypad_scanner_rst         synchronous active-high reset
//   keypad_scanner_iport_row   keypad rows, active-low, asynchronous
//   keypad_scanner_oport_col   column drive, active-low, one-cold
//   keypad_scanner_oport_value entered digits
//   keypad_scanner_oport_key   last accepted key code
//   keypad_scanner_oport_valid one-cycle pulse per accepted key
module keypad_scanner #(
    parameter int unsigned SCAN_TICKS     = 10000,
    parameter int unsigned DEBOUNCE_SCANS = 4
) (
    input  logic        keypad_scanner_clk,
    input  logic        keypad_scanner_rst,
    input  logic [3:0]  keypad_scanner_iport_row,
    output logic [3:0]  keypad_scanner_oport_col,
    output logic [31:0] keypad_scanner_oport_value,
    output logic [3:0]  keypad_scanner_oport_key,
    output logic        keypad_scanner_oport_valid
);

    localparam int unsigned TICK_W = (SCAN_TICKS > 1) ? $clog2(SCAN_TICKS) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SCAN_TICKS - 1);
    localparam logic [3:0] DB_N = 4'(DEBOUNCE_SCANS);

    typedef enum logic [1:0] {ST_SCAN, ST_DEBOUNCE, ST_HOLD} state_e;

    state_e              state_q, state_d;
    logic [3:0]          row_meta_q, row_s_q;
    logic [TICK_W-1:0]   tick_q;
    logic [1:0]          col_idx_q, col_idx_d;
    logic [1:0]          row_q, row_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [3:0]          col_q, col_d;
    logic [3:0]          key_q, key_d;
    logic [31:0]         value_q, value_d;
    logic                valid_q, valid_d;

    logic                sample_c;
    logic                one_low_c;
    logic [1:0]          row_hit_c;
    logic [3:0]          code_c;
    logic [3:0]          cnt_inc_c;
    logic                accept_c;

    // Hex code for row r, column c of the keypad.
    function automatic logic [3:0] key_code(input logic [1:0] r, input logic [1:0] c);
        case ({r, c})
            4'b0000: key_code = 4'h1;
            4'b0001: key_code = 4'h2;
            4'b0010: key_code = 4'h3;
            4'b0011: key_code = 4'hA;
            4'b0100: key_code = 4'h4;
            4'b0101: key_code = 4'h5;
            4'b0110: key_code = 4'h6;
            4'b0111: key_code = 4'hB;
            4'b1000: key_code = 4'h7;
            4'b1001: key_code = 4'h8;
            4'b1010: key_code = 4'h9;
            4'b1011: key_code = 4'hC;
            4'b1100: key_code = 4'h0;
            4'b1101: key_code = 4'hF;
            4'b1110: key_code = 4'hE;
            default: key_code = 4'hD;
        endcase
    endfunction

    // Two-flop row synchronizer; idle (pulled-up) value is all ones.
    always_ff @(posedge keypad_scanner_clk) begin
        if (keypad_scanner_rst) begin
            row_meta_q <= 4'hF;
            row_s_q    <= 4'hF;
        end else begin
            row_meta_q <= keypad_scanner_iport_row;
            row_s_q    <= row_meta_q;
        end
    end

    // Dwell counter; the last count is both the sample point and the wrap.
    assign sample_c = (tick_q == TICK_LAST);

    always_ff @(posedge keypad_scanner_clk) begin
        if (keypad_scanner_rst) begin
            tick_q <= '0;
        end else if (sample_c) begin
            tick_q <= '0;
        end else begin
            tick_q <= tick_q + TICK_W'(1);
        end
    end

    // Exactly-one-row-low detector and its row index.
    always_comb begin
        one_low_c = 1'b1;
        row_hit_c = 2'd0;
        case (row_s_q)
            4'b1110: row_hit_c = 2'd0;
            4'b1101: row_hit_c = 2'd1;
            4'b1011: row_hit_c = 2'd2;
            4'b0111: row_hit_c = 2'd3;
            default: one_low_c = 1'b0;
        endcase
    end

    assign code_c    = key_code(row_hit_c, col_idx_q);
    assign cnt_inc_c = cnt_q + 4'd1;

    // Next-state and output logic; everything is evaluated only at the sample point.
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_d     = row_q;
        cnt_d     = cnt_q;
        key_d     = key_q;
        value_d   = value_q;
        valid_d   = 1'b0;
        accept_c  = 1'b0;

        if (sample_c) begin
            case (state_q)
                ST_SCAN: begin
                    if (one_low_c) begin
                        row_d = row_hit_c;
                        if (DB_N == 4'd1) begin
                            accept_c = 1'b1;
                            state_d  = ST_HOLD;
                            cnt_d    = 4'd0;
                        end else begin
                            cnt_d   = 4'd1;
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        col_idx_d = col_idx_q + 2'd1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (one_low_c && (row_hit_c == row_q)) begin
                        if (cnt_inc_c == DB_N) begin
                            accept_c = 1'b1;
                            state_d  = ST_HOLD;
                            cnt_d    = 4'd0;
                        end else begin
                            cnt_d = cnt_inc_c;
                        end
                    end else begin
                        // Column stays put on this wrap; rotation resumes on the next.
                        state_d = ST_SCAN;
                        cnt_d   = 4'd0;
                    end
                end
                ST_HOLD: begin
                    // Count consecutive all-released samples; any low row restarts it.
                    if (row_s_q == 4'hF) begin
                        if (cnt_inc_c == DB_N) begin
                            state_d   = ST_SCAN;
                            col_idx_d = 2'd0;
                            cnt_d     = 4'd0;
                        end else begin
                            cnt_d = cnt_inc_c;
                        end
                    end else begin
                        cnt_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end

        if (accept_c) begin
            key_d   = code_c;
            valid_d = 1'b1;
`ifdef KEYPAD_SCANNER_CLEAR_EN
            if (code_c == 4'hC) begin
                value_d = 32'd0;
            end else begin
                value_d = {value_q[27:0], code_c};
            end
`else
            value_d = {value_q[27:0], code_c};
`endif
        end
    end

    assign col_d = ~(4'b0001 << col_idx_d);

    // State and output registers.
    always_ff @(posedge keypad_scanner_clk) begin
        if (keypad_scanner_rst) begin
            state_q   <= ST_SCAN;
            col_idx_q <= 2'd0;
            row_q     <= 2'd0;
            cnt_q     <= 4'd0;
            col_q     <= 4'b1110;
            key_q     <= 4'd0;
            value_q   <= 32'd0;
            valid_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_q     <= row_d;
            cnt_q     <= cnt_d;
            col_q     <= col_d;
            key_q     <= key_d;
            value_q   <= value_d;
            valid_q   <= valid_d;
        end
    end

    assign keypad_scanner_oport_col   = col_q;
    assign keypad_scanner_oport_value = value_q;
    assign keypad_scanner_oport_key   = key_q;
    assign keypad_scanner_oport_valid = valid_q;

endmodule
